// File: rtl/count_snapshot_pkg.sv
// Shared constants for the count snapshot FIFO: entry tag encodings and default widths.
package count_snapshot_pkg;

  localparam int TAG_WIDTH = 2;

  localparam logic [TAG_WIDTH-1:0] TAG_CAPTURE = 2'b01;
  localparam logic [TAG_WIDTH-1:0] TAG_WRAP    = 2'b10;
  localparam logic [TAG_WIDTH-1:0] TAG_BOTH    = 2'b11;

  localparam int DROP_CNT_WIDTH_DEFAULT = 8;

endpackage

// File: rtl/count_snapshot_ram.sv
// Register-array storage for the snapshot FIFO: synchronous write, asynchronous read.
module count_snapshot_ram
  import count_snapshot_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int WIDTH  = 8 + TAG_WIDTH,
  parameter int ADDR_W = 2
) (
  input  logic              clk,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [WIDTH-1:0]  rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/count_snapshot_fifo.sv
// Captures counter snapshots on capture/wrap events into a FWFT valid/ready FIFO.
// Define COUNT_SNAPSHOT_DROP_OLDEST_EN to overwrite the oldest entry on overflow.
module count_snapshot_fifo
  import count_snapshot_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int DEPTH          = 4,
  parameter int DROP_CNT_WIDTH = DROP_CNT_WIDTH_DEFAULT
) (
  input  logic                           clk,
  input  logic                           clear,
  input  logic [DATA_WIDTH-1:0]          qd,
  input  logic                           qd_c,
  input  logic                           capture,
  input  logic                           arm,
  output logic [DATA_WIDTH+TAG_WIDTH-1:0] m_tdata,
  output logic                           m_tvalid,
  input  logic                           m_tready,
  output logic [$clog2(DEPTH+1)-1:0]     level,
  output logic [DROP_CNT_WIDTH-1:0]      drop_cnt
);

  localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int LVL_W   = $clog2(DEPTH + 1);
  localparam int ENTRY_W = DATA_WIDTH + TAG_WIDTH;

  logic                      qd_c_q_reg;
  logic [PTR_W-1:0]          rd_ptr_reg, rd_ptr_next;
  logic [PTR_W-1:0]          wr_ptr_reg, wr_ptr_next;
  logic [LVL_W-1:0]          level_reg, level_next;
  logic [DROP_CNT_WIDTH-1:0] drop_cnt_reg, drop_cnt_next;
  logic [ENTRY_W-1:0]        data_reg, data_next;

  logic                      wrap, evt, full, pop;
  logic                      wr_en, rd_adv, drop;
  logic [TAG_WIDTH-1:0]      tag;
  logic [ENTRY_W-1:0]        entry;
  logic [ENTRY_W-1:0]        ram_rd_data;

  assign m_tvalid = (level_reg != '0);
  assign m_tdata  = data_reg;
  assign level    = level_reg;
  assign drop_cnt = drop_cnt_reg;

  always_comb begin
    wrap  = qd_c & ~qd_c_q_reg;
    evt   = arm & (capture | wrap);
    if (capture && wrap) begin
      tag = TAG_BOTH;
    end else if (wrap) begin
      tag = TAG_WRAP;
    end else begin
      tag = TAG_CAPTURE;
    end
    entry = {tag, qd};
    full  = (level_reg == LVL_W'(DEPTH));
    pop   = m_tvalid & m_tready;

`ifdef COUNT_SNAPSHOT_DROP_OLDEST_EN
    // Overflow evicts the head: write into the full slot and advance both pointers.
    wr_en  = evt;
    drop   = evt & full & ~pop;
    rd_adv = pop | drop;
`else
    wr_en  = evt & (~full | pop);
    drop   = evt & full & ~pop;
    rd_adv = pop;
`endif

    wr_ptr_next = wr_en  ? wr_ptr_reg + PTR_W'(1) : wr_ptr_reg;
    rd_ptr_next = rd_adv ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

    level_next = level_reg;
    if (wr_en && !rd_adv) begin
      level_next = level_reg + LVL_W'(1);
    end else if (rd_adv && !wr_en) begin
      level_next = level_reg - LVL_W'(1);
    end

    drop_cnt_next = drop_cnt_reg;
    if (drop && (drop_cnt_reg != '1)) begin
      drop_cnt_next = drop_cnt_reg + DROP_CNT_WIDTH'(1);
    end

    // Registered head: take the entry being written when it lands in the next head slot.
    data_next = data_reg;
    if (level_next != '0) begin
      if (wr_en && (wr_ptr_reg == rd_ptr_next)) begin
        data_next = entry;
      end else begin
        data_next = ram_rd_data;
      end
    end
  end

  count_snapshot_ram #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .ADDR_W(PTR_W)
  ) u_ram (
    .clk    (clk),
    .wr_en  (wr_en),
    .wr_addr(wr_ptr_reg),
    .wr_data(entry),
    .rd_addr(rd_ptr_next),
    .rd_data(ram_rd_data)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      qd_c_q_reg   <= 1'b1;
      rd_ptr_reg   <= '0;
      wr_ptr_reg   <= '0;
      level_reg    <= '0;
      drop_cnt_reg <= '0;
      data_reg     <= '0;
    end else begin
      qd_c_q_reg   <= qd_c;
      rd_ptr_reg   <= rd_ptr_next;
      wr_ptr_reg   <= wr_ptr_next;
      level_reg    <= level_next;
      drop_cnt_reg <= drop_cnt_next;
      data_reg     <= data_next;
    end
  end

endmodule
